// File: rtl/pattern_pkg.sv
// pattern_pkg -- shared types and constants for the serial pattern detector.
//   mode_t      : operating mode decoded from the 2-bit mode input
//   state_t     : detector FSM state (FILL while history is incomplete)
//   PAT_LEN_MIN / PAT_LEN_MAX : legal range of the pattern-length parameter
//   decode_mode : maps the raw mode bits to mode_t (reserved 11 -> PATTERN_OVL)
package pattern_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

  typedef enum logic [1:0] {
    PATTERN_OVL  = 2'b00,
    PATTERN_NOVL = 2'b01,
    RUN          = 2'b10
  } mode_t;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return PATTERN_NOVL;
      2'b10:   return RUN;
      default: return PATTERN_OVL;
    endcase
  endfunction

endpackage

// File: rtl/pattern_detector_param_if.sv
// pattern_detector_param_if -- signal bundle between a stimulus source and
// the pattern detector.
//   d, d_valid   : serial data bit and its qualifier
//   mode         : raw mode bits (see pattern_pkg::decode_mode)
//   pat_in       : target pattern, MSB first in time
//   pat_load     : capture pat_in and restart detection
//   cnt_clr      : clear the match counter
//   q            : registered match indication
//   match_count  : registered saturating count of q assertions
// master drives the controls, slave is the detector.
interface pattern_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);

  logic               d;
  logic               d_valid;
  logic [1:0]         mode;
  logic [PAT_LEN-1:0] pat_in;
  logic               pat_load;
  logic               cnt_clr;
  logic               q;
  logic [CNT_W-1:0]   match_count;

  modport master (
    output d, d_valid, mode, pat_in, pat_load, cnt_clr,
    input  q, match_count
  );

  modport slave (
    input  d, d_valid, mode, pat_in, pat_load, cnt_clr,
    output q, match_count
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter -- W-bit up counter that sticks at all-ones.
//   clk, reset : clock and synchronous active-high reset
//   clr        : clear; a coincident inc leaves the counter at 1
//   inc        : count one event
//   value      : current count
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= inc ? W'(1) : '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pattern_detector_param.sv
// pattern_detector_param -- serial bit-pattern / ones-run detector.
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous active-high reset, highest priority
//   bus   : slave side of pattern_detector_param_if (data, mode, pattern
//           load, counter clear in; q and match_count out)
// PATTERN modes pulse q one cycle after the sample completing the pattern;
// RUN mode holds q high while the current run of ones is >= PAT_LEN.
module pattern_detector_param
  import pattern_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  pattern_detector_param_if.slave  bus
);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("pattern_detector_param: PAT_LEN out of range");
  end

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

  state_t             state, state_nxt;
  mode_t              mode;
  logic [PAT_LEN-1:0] pattern;
  logic [PAT_LEN-1:0] hist, hist_nxt;
  logic [FW-1:0]      fill, fill_nxt;
  logic [FW-1:0]      run, run_nxt;
  logic               q, q_nxt;
  logic               hit;
  logic               inc;
  logic [CNT_W-1:0]   count;

  // Mode is read live, so a new mode applies from the next valid sample.
  assign mode = decode_mode(bus.mode);

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    run_nxt   = run;
    q_nxt     = q;
    hit       = 1'b0;
    inc       = 1'b0;

    if (bus.pat_load) begin
      // Restart detection; any d sampled this cycle is dropped.
      state_nxt = FILL;
      hist_nxt  = '0;
      fill_nxt  = '0;
      run_nxt   = '0;
      q_nxt     = 1'b0;
    end else if (bus.d_valid) begin
      hist_nxt = {hist[PAT_LEN-2:0], bus.d};
      fill_nxt = (fill == FULL) ? fill : fill + FW'(1);
      // Run length saturates at PAT_LEN: that is all q needs to know.
      run_nxt  = !bus.d ? '0 : ((run == FULL) ? run : run + FW'(1));

      case (state)
        FILL: begin
          if (fill_nxt == FULL) begin
            state_nxt = ARMED;
            hit       = (hist_nxt == pattern);
          end
        end
        ARMED:   hit = (hist_nxt == pattern);
        default: state_nxt = FILL;
      endcase

      if (mode == RUN) begin
        q_nxt = (run_nxt == FULL);
        inc   = q_nxt && !q;          // one count per run, on q's rising edge
      end else begin
        q_nxt = hit;
        inc   = hit;
        if (mode == PATTERN_NOVL && hit) begin
          // History is kept but ignored until PAT_LEN fresh samples arrive.
          fill_nxt  = '0;
          state_nxt = FILL;
        end
      end
    end else if (mode != RUN) begin
      q_nxt = 1'b0;                   // PATTERN q is a pulse; RUN q is a level
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FILL;
      pattern <= '0;
      hist    <= '0;
      fill    <= '0;
      run     <= '0;
      q       <= 1'b0;
    end else begin
      state <= state_nxt;
      hist  <= hist_nxt;
      fill  <= fill_nxt;
      run   <= run_nxt;
      q     <= q_nxt;
      if (bus.pat_load) begin
        pattern <= bus.pat_in;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.cnt_clr),
    .inc   (inc),
    .value (count)
  );

  assign bus.q           = q;
  assign bus.match_count = count;

endmodule
